// File: rtl/bcd_display_ctrl.sv
// Signed binary to leading-zero-blanked BCD converter for a 7-segment digit bank.
// Serial double-dabble conversion; outputs update only on completion (done pulse).
module bcd_display_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic                  neg_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [BCD_W-1:0] DIGITS_RST = {DIGITS{4'hF}} << 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_SHIFT,
        S_BLANK,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               sign_q, sign_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   blanked;
    logic               lead;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            value_q   <= '0;
            sign_q    <= 1'b0;
            scratch_q <= '0;
            cnt_q     <= '0;
            digits_q  <= DIGITS_RST;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            sign_q    <= sign_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        sign_d    = sign_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        neg_d     = neg_q;
        adj       = '0;
        blanked   = '0;
        lead      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    value_d = value_in;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                // Most negative input wraps to 2^(WIDTH-1), correct as unsigned magnitude
                sign_d    = value_q[WIDTH-1];
                value_d   = value_q[WIDTH-1] ? WIDTH'(-value_q) : value_q;
                scratch_d = '0;
                cnt_d     = CNT_W'(WIDTH);
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                adj = scratch_q;
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (adj[4*i +: 4] >= 4'd5) begin
                        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                    end
                end
                scratch_d = {adj[BCD_W-2:0], value_q[WIDTH-1]};
                value_d   = {value_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                // Blank leading zeros from the top; the ones digit always shows
                blanked = scratch_q;
                lead    = 1'b1;
                for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
                    if (lead && (blanked[4*i +: 4] == 4'd0)) begin
                        blanked[4*i +: 4] = 4'hF;
                    end else begin
                        lead = 1'b0;
                    end
                end
                digits_d = blanked;
                neg_d    = sign_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ABS) || (state_d == S_SHIFT) || (state_d == S_BLANK);
        done_d = (state_d == S_DONE);
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign digits_out = digits_q;
    assign neg_out    = neg_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Scoreboard bench for bcd_display_ctrl: stimulus queues expected results,
// a negedge monitor checks every done pulse plus handshake invariants.
module tb_bcd_display_ctrl;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DIGITS = 5;
    localparam int LAT = WIDTH + 3;

    logic                clock;
    logic                reset;
    logic [WIDTH-1:0]    value_in;
    logic                load;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] digits_out;
    logic                neg_out;

    typedef struct {
        logic [4*DIGITS-1:0] digits;
        logic                neg;
        int                  cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_run = 0;
    logic mon_en = 1'b0;
    logic rst_seen = 1'b0;
    logic [4*DIGITS-1:0] last_digits;
    logic                last_neg;

    bcd_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .value_in   (value_in),
        .load       (load),
        .busy       (busy),
        .done       (done),
        .digits_out (digits_out),
        .neg_out    (neg_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc      = cyc + 1;
        rst_seen = reset;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse and polices invariants
    always @(negedge clock) begin
        if (mon_en) begin
            check("busy_and_done", 32'(busy & done), 32'd0);
            if (!rst_seen) begin
                last_digits = digits_out;
                last_neg    = neg_out;
                busy_run    = 0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got digits %h want no done (cycle %0d)", digits_out, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("digits", 32'(digits_out), 32'(e.digits));
                    check("neg", 32'(neg_out), 32'(e.neg));
                    check("latency", 32'(cyc), 32'(e.cyc));
                    check("busy_len", 32'(busy_run), 32'(WIDTH + 2));
                end
                last_digits = digits_out;
                last_neg    = neg_out;
                busy_run    = 0;
            end else begin
                check("digits_stable", 32'(digits_out), 32'(last_digits));
                check("neg_stable", 32'(neg_out), 32'(last_neg));
                if (busy) busy_run++;
                else      busy_run = 0;
            end
        end
    end

    task automatic wait_empty();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending results want 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v, input logic [4*DIGITS-1:0] d, input logic n);
        exp_t e;
        load     = 1'b1;
        value_in = v;
        e.digits = d;
        e.neg    = n;
        e.cyc    = cyc + LAT;
        sb.push_back(e);
        @(negedge clock);
        load = 1'b0;
        wait_empty();
    endtask

    initial begin
        int t;
        exp_t e;
        reset    = 1'b0;
        load     = 1'b1;
        value_in = 16'd1234;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_digits", 32'(digits_out), 32'h000FFFF0);
        check("rst_neg", 32'(neg_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset  = 1'b1;
        load   = 1'b0;
        mon_en = 1'b1;
        repeat (25) @(negedge clock);
        check("idle_after_rst_busy", 32'(busy), 32'd0);
        check("idle_after_rst_digits", 32'(digits_out), 32'h000FFFF0);

        do_load(16'd1234, 20'hF1234, 1'b0);
        do_load(16'hFFD6, 20'hFFF42, 1'b1);
        do_load(16'h8000, 20'h32768, 1'b1);
        do_load(16'h7FFF, 20'h32767, 1'b0);
        do_load(16'd0,    20'hFFFF0, 1'b0);
        do_load(16'd10,   20'hFFF10, 1'b0);
        do_load(16'hFFFF, 20'hFFFF1, 1'b1);

        // Held load: value change mid-conversion is ignored, reload at t+20
        t        = cyc;
        load     = 1'b1;
        value_in = 16'd7;
        e.digits = 20'hFFFF7; e.neg = 1'b0; e.cyc = t + LAT;
        sb.push_back(e);
        e.digits = 20'hFFFF9; e.neg = 1'b0; e.cyc = t + 20 + LAT;
        sb.push_back(e);
        @(negedge clock);
        value_in = 16'd9;
        repeat (20) @(negedge clock);
        load = 1'b0;
        wait_empty();

        // Reset during SHIFT aborts with no done pulse
        load     = 1'b1;
        value_in = 16'd500;
        @(negedge clock);
        load = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("abort_digits", 32'(digits_out), 32'h000FFFF0);
        check("abort_neg", 32'(neg_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (30) @(negedge clock);
        do_load(16'd500, 20'hFF500, 1'b0);

        repeat (5) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
